// File: rtl/wfid_read_arbiter.sv
// wfid_read_arbiter: round-robin share of one wfid-indexed read mux with a registered valid/ready response
module wfid_read_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int NUM_ENTRIES = 40,
  parameter int ID_W = 6,
  parameter int DATA_W = 64,
  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_REQ-1:0]      req,
  input  logic [NUM_REQ*ID_W-1:0] req_wfid,
  output logic [NUM_REQ-1:0]      gnt,
  output logic [ID_W-1:0]         mux_select,
  input  logic [DATA_W-1:0]       mux_out,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [IDX_W-1:0]        rsp_id,
  output logic [ID_W-1:0]         rsp_wfid,
  output logic [DATA_W-1:0]       rsp_data,
  output logic                    rsp_err
);
  localparam logic [ID_W:0] ENT = NUM_ENTRIES[ID_W:0];
  logic [IDX_W-1:0] ptr, win;
  logic [ID_W-1:0] sel_wfid;
  logic found, grant, err;
  int idx;
  always_comb begin
    found = 1'b0;
    win = '0;
    idx = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NUM_REQ) idx -= NUM_REQ;
      if (!found && req[IDX_W'(idx)]) begin
        found = 1'b1;
        win = IDX_W'(idx);
      end
    end
  end
  assign sel_wfid = req_wfid[win*ID_W +: ID_W];
  assign err = {1'b0, sel_wfid} >= ENT;
  assign grant = !rst && (!rsp_valid || rsp_ready) && found;
  assign gnt = grant ? NUM_REQ'(1) << win : '0;
  assign mux_select = grant ? sel_wfid : '0;
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
      rsp_valid <= 1'b0;
      rsp_id <= '0;
      rsp_wfid <= '0;
      rsp_data <= '0;
      rsp_err <= 1'b0;
    end else if (grant) begin
      ptr <= (win == IDX_W'(NUM_REQ - 1)) ? '0 : win + 1'b1;
      rsp_valid <= 1'b1;
      rsp_id <= win;
      rsp_wfid <= sel_wfid;
      rsp_data <= err ? '0 : mux_out;
      rsp_err <= err;
    end else if (rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_wfid_read_arbiter.sv
// tb_wfid_read_arbiter: directed self-checking bench for wfid_read_arbiter
module tb_wfid_read_arbiter;
  logic clk = 0, rst = 1, rsp_ready = 1;
  logic [3:0] req = '0, gnt;
  logic [5:0] w [4];
  logic [23:0] req_wfid;
  logic [5:0] mux_select, rsp_wfid;
  logic [63:0] mux_out, rsp_data;
  logic [1:0] rsp_id;
  logic rsp_valid, rsp_err;
  int n_tests = 0, n_fail = 0;
  logic [5:0] cw [4];
  always #5 clk = ~clk;
  function automatic logic [63:0] ent(input int k);
    return {32'hA5A5_0000 + 32'(k), 32'(k)};
  endfunction
  assign req_wfid = {w[3], w[2], w[1], w[0]};
  assign mux_out = (mux_select < 6'd40) ? ent(int'(mux_select)) : 64'hDEAD_BEEF_DEAD_BEEF;
  wfid_read_arbiter dut (
    .clk(clk), .rst(rst), .req(req), .req_wfid(req_wfid), .gnt(gnt),
    .mux_select(mux_select), .mux_out(mux_out), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_wfid(rsp_wfid),
    .rsp_data(rsp_data), .rsp_err(rsp_err)
  );
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic chk_rsp(input string tag, input int id, input int wf, input logic [63:0] d, input logic e);
    chk({tag, "_valid"}, 64'(rsp_valid), 64'd1);
    chk({tag, "_id"}, 64'(rsp_id), 64'(id));
    chk({tag, "_wfid"}, 64'(rsp_wfid), 64'(wf));
    chk({tag, "_data"}, rsp_data, d);
    chk({tag, "_err"}, 64'(rsp_err), 64'(e));
  endtask
  initial begin
    for (int i = 0; i < 4; i++) w[i] = '0;
    cw[0] = 6'd3; cw[1] = 6'd17; cw[2] = 6'd30; cw[3] = 6'd39;
    repeat (2) @(negedge clk);
    chk("rst_valid", 64'(rsp_valid), 64'd0);
    chk("rst_gnt", 64'(gnt), 64'd0);
    chk("rst_sel", 64'(mux_select), 64'd0);
    rst = 0; req = 4'b0100; w[2] = 6'd5;
    #1 chk("single_gnt", 64'(gnt), 64'b0100);
    chk("single_sel", 64'(mux_select), 64'd5);
    @(negedge clk);
    chk_rsp("single", 2, 5, ent(5), 1'b0);
    req = '0;
    #1 chk("idle_gnt", 64'(gnt), 64'd0);
    chk("idle_sel", 64'(mux_select), 64'd0);
    @(negedge clk);
    chk("idle_valid", 64'(rsp_valid), 64'd0);
    rst = 1;
    @(negedge clk);
    rst = 0; req = 4'b1111;
    for (int i = 0; i < 4; i++) w[i] = cw[i];
    #1 chk("cont_gnt0", 64'(gnt), 64'b0001);
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      chk_rsp("cont", (c - 1) % 4, int'(cw[(c - 1) % 4]), ent(int'(cw[(c - 1) % 4])), 1'b0);
      #1 chk("cont_gnt", 64'(gnt), 64'(4'b0001 << (c % 4)));
    end
    @(negedge clk);
    chk_rsp("cont_last", 0, 3, ent(3), 1'b0);
    req = 4'b0010; w[1] = 6'd8;
    #1 chk("fair_gnt1", 64'(gnt), 64'b0010);
    @(negedge clk);
    chk_rsp("fair1", 1, 8, ent(8), 1'b0);
    req = 4'b0011; w[0] = 6'd4;
    #1 chk("fair_gnt0", 64'(gnt), 64'b0001);
    @(negedge clk);
    chk_rsp("fair0", 0, 4, ent(4), 1'b0);
    req = 4'b0010;
    #1 chk("fair_gnt1b", 64'(gnt), 64'b0010);
    @(negedge clk);
    chk_rsp("fair1b", 1, 8, ent(8), 1'b0);
    req = 4'b1000; w[3] = 6'd12; rsp_ready = 0;
    #1 chk("bp_gnt", 64'(gnt), 64'd0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk_rsp("bp_hold", 1, 8, ent(8), 1'b0);
      #1 chk("bp_gnt_hold", 64'(gnt), 64'd0);
    end
    rsp_ready = 1;
    #1 chk("bp_rel_gnt", 64'(gnt), 64'b1000);
    chk("bp_rel_sel", 64'(mux_select), 64'd12);
    @(negedge clk);
    chk_rsp("bp_new", 3, 12, ent(12), 1'b0);
    req = 4'b0001; w[0] = 6'd40;
    #1 chk("oor_sel40", 64'(mux_select), 64'd40);
    @(negedge clk);
    chk_rsp("oor40", 0, 40, 64'd0, 1'b1);
    w[0] = 6'd63;
    #1 chk("oor_gnt63", 64'(gnt), 64'b0001);
    @(negedge clk);
    chk_rsp("oor63", 0, 63, 64'd0, 1'b1);
    w[0] = 6'd39;
    @(negedge clk);
    chk_rsp("in39", 0, 39, ent(39), 1'b0);
    req = 4'b0010; w[1] = 6'd7;
    @(negedge clk);
    chk_rsp("pre_rst", 1, 7, ent(7), 1'b0);
    req = 4'b1010; w[3] = 6'd9; rsp_ready = 0;
    #1 chk("pre_rst_gnt", 64'(gnt), 64'd0);
    @(negedge clk);
    rst = 1; rsp_ready = 1;
    #1 chk("mid_rst_gnt", 64'(gnt), 64'd0);
    chk("mid_rst_sel", 64'(mux_select), 64'd0);
    @(negedge clk);
    chk("post_rst_valid", 64'(rsp_valid), 64'd0);
    chk("post_rst_data", rsp_data, 64'd0);
    chk("post_rst_id", 64'(rsp_id), 64'd0);
    rst = 0;
    #1 chk("post_rst_gnt", 64'(gnt), 64'b0010);
    chk("post_rst_sel", 64'(mux_select), 64'd7);
    @(negedge clk);
    chk_rsp("post_rst", 1, 7, ent(7), 1'b0);
    req = '0;
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/wfid_read_arbiter.md
Name: wfid_read_arbiter

Overview:
- Shares one 40-entry x 64-bit per-wavefront read mux (select in, 64-bit data out, combinational) among NUM_REQ requesters, e.g. issue, exec-mask and debug readers.
- Arbitrates with a round-robin policy.
- Drives the mux select, registers the selected 64-bit word, and returns it on a single response channel with valid/ready backpressure.
- Flags out-of-range wavefront IDs.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- NUM_ENTRIES, 40, number of valid mux entries; wfid >= NUM_ENTRIES is out of range.
- ID_W, 6, wavefront ID / mux select width.
- DATA_W, 64, entry width.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous active-high reset.
- req  input  NUM_REQ  per-requester request; held until granted.
- req_wfid  input  NUM_REQ*ID_W  requester i wfid at [i*ID_W +: ID_W]; stable while req[i] is high.
- gnt  output  NUM_REQ  one-hot grant, combinational, at most one bit set.
- mux_select  output  ID_W  select to the mux; equals the granted wfid, 0 when idle.
- mux_out  input  DATA_W  mux data for mux_select, same cycle.
- rsp_valid  output  1  response valid.
- rsp_ready  input  1  consumer accepts response.
- rsp_id  output  clog2(NUM_REQ)  index of the requester served.
- rsp_wfid  output  ID_W  wfid served.
- rsp_data  output  DATA_W  registered entry data.
- rsp_err  output  1  wfid was out of range; rsp_data forced to 0.

Behaviour:
- **Slot free condition:** slot_free = !rsp_valid || rsp_ready.
  - Grant is issued only when slot_free is high and any req bit is set.
  - Otherwise gnt = 0 and mux_select = 0.
- **Round-robin arbitration:**
  - Pointer ptr, width clog2(NUM_REQ), reset to 0.
  - Winner is the first i with req[i] set, scanning ptr, ptr+1, ... modulo NUM_REQ.
  - On grant to i, ptr <= (i+1) mod NUM_REQ.
  - ptr is unchanged when there is no grant.
- **Mux drive:** in the grant cycle T, mux_select = req_wfid slice of the winner, and mux_out is sampled at the end of T.
- **Latency:** exactly 1 cycle. At T+1:
  - rsp_valid = 1
  - rsp_id = winner
  - rsp_wfid = wfid
  - rsp_data = mux_out sampled at T, or 0 if out of range
  - rsp_err = (wfid >= NUM_ENTRIES)
- **Backpressure:**
  - While rsp_valid && !rsp_ready, all rsp_* outputs hold and no grant is issued.
  - Requests remain pending; req must stay asserted.
- **Back-to-back:** if rsp_valid && rsp_ready in cycle T and a request is pending, a new grant occurs in T. The response register is overwritten at T+1, giving one grant per cycle at full throughput.
- **Response register update:**
  - No grant and rsp_ready high: rsp_valid <= 0, and other rsp_* fields hold their last values.
  - No grant and rsp_ready low: all rsp_* fields hold.
- **Out-of-range wfid:**
  - Still consumes a grant and a response slot.
  - mux_select carries the raw wfid; the mux X default is masked because rsp_data is forced to 0.
  - wfid 40..63 gives rsp_err = 1.
- **Requester handshake:** gnt[i] is a one-cycle pulse per grant. The requester may keep req[i] high with a new wfid the next cycle; it is then treated as a new request.
- **Reset:**
  - While rst is high: gnt = 0, mux_select = 0.
  - At the edge: rsp_valid, rsp_id, rsp_wfid, rsp_data, rsp_err <= 0 and ptr <= 0.
  - Reset asserted with a response pending or a grant in flight discards it; no response follows reset.
- **No X propagation:** all outputs are defined whenever rst has been applied. When NUM_REQ is not a power of 2, ptr wraps via explicit compare.

Test Plan:
- **Single request:** mux model entry k = {32'hA5A5_0000 + k, 32'h0000_0000 + k}. req[2]=1 with wfid 5 at T -> gnt=4'b0100 and mux_select=5 at T; rsp_valid=1, rsp_id=2, rsp_wfid=5, rsp_data=entry 5, rsp_err=0 at T+1.
- **Full contention:** req=4'b1111 held with wfids {3,17,30,39}, rsp_ready=1 after reset -> grants 0,1,2,3,0,... on consecutive cycles; responses carry entries 3,17,30,39 with rsp_id 0,1,2,3, one per cycle.
- **Fairness after pointer move:** grant to 1, then req=4'b0011 -> next grant goes to 0, not 1. Then req=4'b0010 -> grant to 1.
- **Backpressure:** rsp_ready=0 for 3 cycles while rsp_valid=1 and req[3] pending -> rsp_* stable for 3 cycles and gnt=0. Then rsp_ready=1 -> gnt[3] in the same cycle and the new response in the next cycle.
- **Out of range:** wfid 40 and wfid 63 -> rsp_err=1 and rsp_data=64'h0. Then wfid 39 -> rsp_err=0 and rsp_data=entry 39.
- **Reset mid-operation:** assert rst while rsp_valid=1, rsp_ready=0 and req=4'b1010 -> the cycle after rst, rsp_valid=0, gnt=0 during rst, ptr=0. After release the first grant goes to 1.
